// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback path.
// Holds widths, the x0 index and the round-robin source enum.
package riscv_rf_pkg;

  localparam int XLEN     = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback handshake bundle: valid/ready plus destination and data.
// master = producing unit (ALU/LSU), slave = the writeback arbiter.
interface regfile_wb_arbiter_if;
  import riscv_rf_pkg::*;

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] rd;
  logic [XLEN-1:0]   data;

  modport master (
    output valid, rd, data,
    input  ready
  );

  modport slave (
    input  valid, rd, data,
    output ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with one-hot grant.
// Ports: clk, rst_n, req[1:0] (0=ALU, 1=LSU), gnt[1:0].
module rr_arb2
  import riscv_rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  src_e       rr_ptr;
  logic [1:0] pick;

  always_comb begin
    pick = 2'b00;
    unique case (1'b1)
      (req == 2'b11): pick = (rr_ptr == SRC_ALU) ? 2'b01 : 2'b10;
      (req == 2'b01): pick = 2'b01;
      (req == 2'b10): pick = 2'b10;
      default:        pick = 2'b00;
    endcase
  end

  // No grant may be handed out while reset is held.
  assign gnt = rst_n ? pick : 2'b00;

  // Only a contested grant moves the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SRC_ALU;
    end else if (req == 2'b11) begin
      rr_ptr <= gnt[0] ? SRC_LSU : SRC_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and LSU writeback
// and tracks a per-register busy scoreboard for decode hazard checks.
module regfile_wb_arbiter
  import riscv_rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave alu_wb,
  regfile_wb_arbiter_if.slave lsu_wb,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rf_write_enable,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [XLEN-1:0]     rf_write_data
);

  logic [1:0]          gnt;
  logic                grant;
  logic [ADDR_W-1:0]   wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({lsu_wb.valid, alu_wb.valid}),
    .gnt   (gnt)
  );

  assign alu_wb.ready = gnt[0];
  assign lsu_wb.ready = gnt[1];
  assign grant        = |gnt;

  always_comb begin
    wb_rd   = alu_wb.rd;
    wb_data = alu_wb.data;
    if (gnt[1]) begin
      wb_rd   = lsu_wb.rd;
      wb_data = lsu_wb.data;
    end
  end

  // x0 writes are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= grant && (wb_rd != REG_ZERO);
      if (grant) begin
        rf_write_addr <= wb_rd;
        rf_write_data <= wb_data;
      end
    end
  end

  // Set after clear: a new producer issued on the same edge owns rd.
  always_comb begin
    busy_nxt = busy;
    if (grant) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (iss_valid && iss_rd != REG_ZERO) begin
      busy_nxt[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs1_busy = (rs1_addr != REG_ZERO) && busy[rs1_addr];
  assign rs2_busy = (rs2_addr != REG_ZERO) && busy[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + random bench for regfile_wb_arbiter against a
// behavioural scoreboard/arbitration/register-file model.
module tb_regfile_wb_arbiter;
  import riscv_rf_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  regfile_wb_arbiter_if alu_if ();
  regfile_wb_arbiter_if lsu_if ();

  regfile_wb_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_wb          (alu_if),
    .lsu_wb          (lsu_if),
    .iss_valid       (iss_valid),
    .iss_rd          (iss_rd),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_busy        (rs1_busy),
    .rs2_busy        (rs2_busy),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // registers32 stand-in: x0 hardwired, write-through bypass
  logic [31:0] rf_mem [32];
  always @(posedge clk)
    if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (rf_write_enable && rf_write_addr == a) return rf_write_data;
    return rf_mem[a];
  endfunction

  // reference model
  bit          m_busy [32];
  bit          m_turn_lsu;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_mem [32];
  bit          g_alu, g_lsu;
  logic        o_alu_rdy, o_lsu_rdy;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we && m_addr == a) return m_data;
    return m_mem[a];
  endfunction

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_turn_lsu = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, take the edge, update
  // the model, then check the registered write port.
  task automatic cycle();
    bit          av, lv, iv;
    logic [4:0]  rd, ir;
    logic [31:0] d;
    #1;
    av = alu_if.valid;
    lv = lsu_if.valid;
    iv = iss_valid;
    ir = iss_rd;
    g_alu = av && (!lv || !m_turn_lsu);
    g_lsu = lv && (!av || m_turn_lsu);
    rd = g_lsu ? lsu_if.rd : alu_if.rd;
    d  = g_lsu ? lsu_if.data : alu_if.data;
    o_alu_rdy = alu_if.ready;
    o_lsu_rdy = lsu_if.ready;
    chk("alu_ready", alu_if.ready, g_alu);
    chk("lsu_ready", lsu_if.ready, g_lsu);
    chk("rs1_busy", rs1_busy, rs1_addr != 0 && m_busy[rs1_addr]);
    chk("rs2_busy", rs2_busy, rs2_addr != 0 && m_busy[rs2_addr]);
    @(posedge clk);
    if (m_we) m_mem[m_addr] = m_data;
    if (av && lv) m_turn_lsu = g_alu;
    if (g_alu || g_lsu) begin
      m_we   = (rd != 0);
      m_addr = rd;
      m_data = d;
      m_busy[rd] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (iv && ir != 0) m_busy[ir] = 1'b1;
    #1;
    chk("rf_we", rf_write_enable, m_we);
    chk("rf_addr", rf_write_addr, m_addr);
    chk("rf_data", rf_write_data, m_data);
    chk("rf_read", rf_read(rs1_addr), m_read(rs1_addr));
  endtask

  task automatic idle_inputs();
    alu_if.valid = 0; alu_if.rd = 0; alu_if.data = 0;
    lsu_if.valid = 0; lsu_if.rd = 0; lsu_if.data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a_d, l_d, exp_d;
    foreach (rf_mem[i]) rf_mem[i] = '0;
    foreach (m_mem[i]) m_mem[i] = '0;
    m_reset();
    idle_inputs();
    rs1_addr = 0;
    rs2_addr = 0;

    // reset: readies held low even with both sources valid
    rst_n = 1'b0;
    alu_if.valid = 1; lsu_if.valid = 1;
    alu_if.rd = 5'd9; lsu_if.rd = 5'd10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_ready", alu_if.ready, 1'b0);
    chk("rst_lsu_ready", lsu_if.ready, 1'b0);
    chk("rst_we", rf_write_enable, 1'b0);
    chk("rst_addr", rf_write_addr, 5'd0);
    chk("rst_data", rf_write_data, 32'h0);
    for (int a = 0; a < 32; a += 5) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      chk("rst_rs1_busy", rs1_busy, 1'b0);
      chk("rst_rs2_busy", rs2_busy, 1'b0);
    end
    idle_inputs();
    rst_n = 1'b1;
    rs1_addr = 0; rs2_addr = 0;
    cycle();

    // issue x5, then ALU writes it back two cycles later
    iss_valid = 1; iss_rd = 5'd5; rs1_addr = 5'd5;
    cycle();
    iss_valid = 0;
    #1;
    chk("x5_busy_after_iss", rs1_busy, 1'b1);
    cycle();
    alu_if.valid = 1; alu_if.rd = 5'd5; alu_if.data = 32'hDEADBEEF;
    cycle();
    alu_if.valid = 0;
    #1;
    chk("x5_we", rf_write_enable, 1'b1);
    chk("x5_addr", rf_write_addr, 5'd5);
    chk("x5_data", rf_write_data, 32'hDEADBEEF);
    chk("x5_not_busy", rs1_busy, 1'b0);
    chk("x5_read", rf_read(5'd5), 32'hDEADBEEF);
    cycle();

    // both valid from reset: ALU, LSU, ALU, LSU
    do_reset();
    a_d = 32'h1000_0001;
    l_d = 32'h2000_0002;
    for (int k = 0; k < 4; k++) begin
      alu_if.valid = 1; alu_if.rd = 5'd1; alu_if.data = a_d;
      lsu_if.valid = 1; lsu_if.rd = 5'd2; lsu_if.data = l_d;
      exp_d = (k % 2 == 0) ? a_d : l_d;
      cycle();
      chk("rr_alu_ready", o_alu_rdy, (k % 2 == 0));
      chk("rr_lsu_ready", o_lsu_rdy, (k % 2 == 1));
      chk("rr_data", rf_write_data, exp_d);
      if (k % 2 == 0) a_d = a_d + 1;
      else l_d = l_d + 1;
    end
    idle_inputs();

    // LSU write to x0 is accepted and dropped
    lsu_if.valid = 1; lsu_if.rd = 5'd0; lsu_if.data = 32'h98761234;
    rs1_addr = 5'd0;
    cycle();
    lsu_if.valid = 0;
    chk("x0_ready", o_lsu_rdy, 1'b1);
    chk("x0_we", rf_write_enable, 1'b0);
    chk("x0_read", rf_read(5'd0), 32'h0);

    // same-edge issue and writeback of x7: set wins
    iss_valid = 1; iss_rd = 5'd7;
    alu_if.valid = 1; alu_if.rd = 5'd7; alu_if.data = 32'h0707_0707;
    rs1_addr = 5'd7;
    cycle();
    idle_inputs();
    #1;
    chk("x7_busy", rs1_busy, 1'b1);
    chk("x7_we", rf_write_enable, 1'b1);
    chk("x7_addr", rf_write_addr, 5'd7);

    // async reset mid-cycle with x3 busy and a write pending
    iss_valid = 1; iss_rd = 5'd3; rs1_addr = 5'd3;
    cycle();
    iss_valid = 0;
    alu_if.valid = 1; alu_if.rd = 5'd4; alu_if.data = 32'h4444_4444;
    cycle();
    chk("pre_rst_we", rf_write_enable, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", rf_write_enable, 1'b0);
    chk("arst_addr", rf_write_addr, 5'd0);
    chk("arst_data", rf_write_data, 32'h0);
    chk("arst_alu_ready", alu_if.ready, 1'b0);
    chk("arst_rs1_busy", rs1_busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    idle_inputs();
    #1;
    chk("x3_clear_after_rst", rs1_busy, 1'b0);
    g_alu = 0; g_lsu = 0;

    // randomized traffic; held transfers keep rd/data stable
    for (int i = 0; i < 400; i++) begin
      if (!alu_if.valid || g_alu) begin
        alu_if.valid = ($urandom_range(0, 2) != 0);
        alu_if.rd    = 5'($urandom_range(0, 7));
        alu_if.data  = $urandom;
      end
      if (!lsu_if.valid || g_lsu) begin
        lsu_if.valid = ($urandom_range(0, 2) != 0);
        lsu_if.rd    = 5'($urandom_range(0, 7));
        lsu_if.data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      rs1_addr  = 5'($urandom_range(0, 8));
      rs2_addr  = ($urandom_range(0, 9) == 0) ? 5'd31
                                              : 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file (registers32) between two writeback sources: ALU and load/store unit (LSU).
- Holds a per-register busy scoreboard. Decode queries it to stall on read-after-write hazards.
- Sits between the execute/memory stages and registers32.
- Drives a registered write port. It relies on the register file's hardwired x0 and its write-through read bypass.

Parameters:
XLEN, 32, data width of the register file
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_wb_valid  input  1  ALU has a writeback pending
alu_wb_ready  output  1  ALU writeback accepted this cycle
alu_wb_rd  input  ADDR_W  ALU destination register
alu_wb_data  input  XLEN  ALU result
lsu_wb_valid  input  1  LSU has a writeback pending
lsu_wb_ready  output  1  LSU writeback accepted this cycle
lsu_wb_rd  input  ADDR_W  LSU destination register
lsu_wb_data  input  XLEN  LSU load data
iss_valid  input  1  an instruction with a destination register issues
iss_rd  input  ADDR_W  destination of the issuing instruction
rs1_addr  input  ADDR_W  decode source 1 query
rs2_addr  input  ADDR_W  decode source 2 query
rs1_busy  output  1  rs1 has an outstanding write
rs2_busy  output  1  rs2 has an outstanding write
rf_write_enable  output  1  to registers32 write_enable
rf_write_addr  output  ADDR_W  to registers32 write_addr
rf_write_data  output  XLEN  to registers32 write_data

Behaviour:
- Reset (rst_n low, asynchronous): rf_write_enable=0, rf_write_addr=0, rf_write_data=0, busy[all]=0, rr_ptr=ALU (ALU preferred).
- Ready outputs are 0 while in reset.
- Handshake: a transfer occurs on a rising edge where valid && ready. Ready is combinational from the valid signals and rr_ptr. Ready never depends on the data inputs.
- Source data must stay stable while valid && !ready.
- Arbitration, one grant per cycle:
  - Only one source valid: that source is granted.
  - Both valid: the source selected by rr_ptr is granted.
  - Neither valid: no grant.
- rr_ptr update: after a contested grant, rr_ptr points to the other source. An uncontested grant leaves rr_ptr unchanged.
- Write port is registered with latency 1. On the grant edge: rf_write_addr<=rd, rf_write_data<=data, rf_write_enable<=(rd!=0).
- With no grant: rf_write_enable<=0, and addr/data hold their previous values.
- Writes to x0 are accepted (ready asserted) and dropped: rf_write_enable stays 0.
- Scoreboard set: busy[iss_rd]<=1 on an edge with iss_valid && iss_rd!=0.
- Scoreboard clear: busy[rd]<=0 on the grant edge of a writeback to rd.
- Simultaneous set and clear of the same rd: set wins (the new producer owns the register).
- Query outputs: rsN_busy = busy[rsN_addr], combinational; 0 whenever rsN_addr==0.
- A register is not busy in the cycle its write appears on rf_write_*. The registers32 write-through bypass supplies the data on that cycle.
- Ordering: two writebacks to the same rd commit in grant order; the last grant defines the final value.
- Reset mid-transfer: the pending write is lost, the output register clears, and the scoreboard clears. Upstream must reissue.

Decomposition:
- Package riscv_rf_pkg holds:
  - XLEN, ADDR_W, NUM_REGS
  - REG_ZERO=5'd0
  - src_e enum {SRC_ALU=0, SRC_LSU=1} used for rr_ptr
- One natural sub-module: rr_arb2, a two-requester round-robin arbiter. Inputs: req[1:0], clk, rst_n. Output: one-hot gnt[1:0]. It owns the priority flop.
- Scoreboard and output register stay in regfile_wb_arbiter.

Test Plan:
- Reset then idle: all outputs 0, rs1_busy=rs2_busy=0 for any address, both readies 0 during rst_n=0.
- iss rd=5, then ALU wb rd=5 data=32'hDEADBEEF two cycles later:
  - rs1_addr=5 gives busy=1 from the cycle after issue until the grant edge.
  - Next cycle: rf_write_enable=1, addr=5, data=DEADBEEF.
  - registers32 read of x5 returns DEADBEEF.
- Both valid for 4 cycles (ALU rd=1 data=1..., LSU rd=2 data=2...) from reset:
  - Grants in order ALU, LSU, ALU, LSU, with one ready high per cycle.
  - Held data is presented unchanged until accepted.
- LSU wb rd=0 data=32'h98761234: lsu_wb_ready=1, rf_write_enable stays 0, and a read of x0 returns 0.
- Same-edge iss_valid rd=7 and ALU wb rd=7 grant: busy[7]=1 afterwards, while the write still appears on rf_write_* with addr 7.
- Assert rst_n=0 asynchronously mid-cycle with busy[3]=1 and a write pending: outputs go to 0 immediately without a clock edge, and busy[3]=0 after release.
